multi_cycle_controller: RTL and testbench

Sequencing control FSM for the multi-cycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back, driving the ALU operand muxes, PC update, memory strobes and register-file write-back selection. It waits on a memory ready handshake and halts on an illegal opcode. It sits beside the datapath, consuming the latched IR opcode and the ALU zero flag.

---
 rtl/multi_cycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// ============================================================================
// Module   : multi_cycle_controller
// Brief    : Sequencing FSM for a multi-cycle MIPS datapath (fetch..write-back).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_controller #(
    parameter int WIDTH_OP = 6
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [WIDTH_OP-1:0] opcode,
    input  logic                aluZero,
    input  logic                memReady,
    output logic                pcWrite,
    output logic [1:0]          pcSrc,
    output logic                irWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic                memAddrSel,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOp,
    output logic                regWrite,
    output logic [1:0]          regDst,
    output logic [1:0]          wbSel,
    output logic                instRetire,
    output logic                halted,
    output logic [3:0]          state
);

    localparam logic [WIDTH_OP-1:0] OP_RTYPE = WIDTH_OP'(8'h00);
    localparam logic [WIDTH_OP-1:0] OP_J     = WIDTH_OP'(8'h02);
    localparam logic [WIDTH_OP-1:0] OP_JAL   = WIDTH_OP'(8'h03);
    localparam logic [WIDTH_OP-1:0] OP_BEQ   = WIDTH_OP'(8'h04);
    localparam logic [WIDTH_OP-1:0] OP_ADDI  = WIDTH_OP'(8'h08);
    localparam logic [WIDTH_OP-1:0] OP_LW    = WIDTH_OP'(8'h23);
    localparam logic [WIDTH_OP-1:0] OP_SW    = WIDTH_OP'(8'h2B);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        MEM_RD = 4'd3,
        MEM_WR = 4'd4,
        WB_ALU = 4'd5,
        WB_MEM = 4'd6,
        BRANCH = 4'd7,
        JUMP   = 4'd8,
        HALT   = 4'd9
    } state_t;

    state_t              cur_state;
    logic [WIDTH_OP-1:0] op_q;

    // Opcode is captured while leaving DECODE so later IR changes are ignored.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cur_state <= FETCH;
            op_q      <= '0;
        end else begin
            case (cur_state)
                FETCH:  if (memReady) cur_state <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    if (opcode == OP_RTYPE || opcode == OP_ADDI ||
                        opcode == OP_LW    || opcode == OP_SW)
                        cur_state <= EXEC;
                    else if (opcode == OP_BEQ)
                        cur_state <= BRANCH;
                    else if (opcode == OP_J || opcode == OP_JAL)
                        cur_state <= JUMP;
                    else
                        cur_state <= HALT;
                end
                EXEC: begin
                    if (op_q == OP_RTYPE || op_q == OP_ADDI) cur_state <= WB_ALU;
                    else if (op_q == OP_LW)                  cur_state <= MEM_RD;
                    else                                     cur_state <= MEM_WR;
                end
                MEM_RD: if (memReady) cur_state <= WB_MEM;
                MEM_WR: if (memReady) cur_state <= FETCH;
                WB_ALU, WB_MEM, BRANCH, JUMP: cur_state <= FETCH;
                HALT:    cur_state <= HALT;
                default: cur_state <= HALT;
            endcase
        end
    end

    always_comb begin
        pcWrite    = 1'b0;
        pcSrc      = 2'd0;
        irWrite    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memAddrSel = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'd0;
        aluOp      = 2'd0;
        regWrite   = 1'b0;
        regDst     = 2'd0;
        wbSel      = 2'd0;
        instRetire = 1'b0;
        halted     = 1'b0;
        case (cur_state)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'd1;
                // Gated by rstN so no load strobe escapes while held in reset.
                irWrite = memReady & rstN;
                pcWrite = memReady & rstN;
            end
            DECODE: aluSrcB = 2'd3;
            EXEC: begin
                aluSrcA = 1'b1;
                if (op_q == OP_RTYPE) begin
                    aluSrcB = 2'd0;
                    aluOp   = 2'd2;
                end else begin
                    aluSrcB = 2'd2;
                end
            end
            MEM_RD: begin
                memRead    = 1'b1;
                memAddrSel = 1'b1;
            end
            MEM_WR: begin
                memWrite   = 1'b1;
                memAddrSel = 1'b1;
                instRetire = memReady;
            end
            WB_ALU: begin
                regWrite   = 1'b1;
                regDst     = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
                instRetire = 1'b1;
            end
            WB_MEM: begin
                regWrite   = 1'b1;
                wbSel      = 2'd1;
                instRetire = 1'b1;
            end
            BRANCH: begin
                aluSrcA    = 1'b1;
                aluOp      = 2'd1;
                pcSrc      = 2'd1;
                pcWrite    = aluZero;
                instRetire = 1'b1;
            end
            JUMP: begin
                pcWrite    = 1'b1;
                pcSrc      = 2'd2;
                instRetire = 1'b1;
                if (op_q == OP_JAL) begin
                    regWrite = 1'b1;
                    regDst   = 2'd2;
                    wbSel    = 2'd2;
                end
            end
            HALT:    halted = 1'b1;
            default: halted = 1'b1;
        endcase
    end

    assign state = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
// ============================================================================
// Module   : tb_multi_cycle_controller
// Brief    : Randomized self-checking bench; expected per-cycle traces are built
//            from each instruction's step sequence and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] opcode;
    logic       aluZero;
    logic       memReady;
    logic       pcWrite, irWrite, memRead, memWrite, memAddrSel, aluSrcA;
    logic       regWrite, instRetire, halted;
    logic [1:0] pcSrc, aluSrcB, aluOp, regDst, wbSel;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    multi_cycle_controller #(.WIDTH_OP(6)) dut (
        .clk(clk), .rstN(rstN), .opcode(opcode), .aluZero(aluZero),
        .memReady(memReady), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
        .memAddrSel(memAddrSel), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .regWrite(regWrite), .regDst(regDst), .wbSel(wbSel),
        .instRetire(instRetire), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, mr, mw, mas, asa;
        logic [1:0] asb, aop;
        logic       rw;
        logic [1:0] rd, wbs;
        logic       ret, hlt;
    } outv_t;

    typedef struct {
        logic       mrdy;
        logic       az;
        logic [5:0] op;
        outv_t      exp;
    } cyc_t;

    cyc_t q[$];

    localparam outv_t RST_V = '{st: 4'd0, mr: 1'b1, asb: 2'd1, default: '0};

    function automatic outv_t sample();
        outv_t v;
        v.st = state;   v.pcw = pcWrite; v.pcs = pcSrc;   v.irw = irWrite;
        v.mr = memRead; v.mw = memWrite; v.mas = memAddrSel; v.asa = aluSrcA;
        v.asb = aluSrcB; v.aop = aluOp;  v.rw = regWrite; v.rd = regDst;
        v.wbs = wbSel;  v.ret = instRetire; v.hlt = halted;
        return v;
    endfunction

    function automatic outv_t z(input int st);
        outv_t v = '0;
        v.st = 4'(st);
        return v;
    endfunction

    task automatic chk(input string name, input outv_t exp);
        outv_t act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic mrdy, input logic az, input logic [5:0] op,
                        input outv_t v);
        cyc_t e;
        e.mrdy = mrdy; e.az = az; e.op = op; e.exp = v;
        q.push_back(e);
    endtask

    task automatic push_any(input outv_t v);
        push(1'($urandom), 1'($urandom), 6'($urandom), v);
    endtask

    // Expected trace of one instruction: fs fetch stalls, ms memory stalls.
    task automatic plan(input logic [5:0] op, input int fs, input int ms,
                        input logic az);
        outv_t v;
        for (int i = 0; i < fs; i++) begin
            v = z(0); v.mr = 1; v.asb = 1;
            push(1'b0, 1'($urandom), 6'($urandom), v);
        end
        v = z(0); v.mr = 1; v.asb = 1; v.irw = 1; v.pcw = 1;
        push(1'b1, 1'($urandom), 6'($urandom), v);
        v = z(1); v.asb = 3;
        push(1'($urandom), 1'($urandom), op, v);
        case (op)
            6'h04: begin
                v = z(7); v.asa = 1; v.aop = 1; v.pcs = 1; v.pcw = az; v.ret = 1;
                push(1'($urandom), az, 6'($urandom), v);
            end
            6'h02, 6'h03: begin
                v = z(8); v.pcw = 1; v.pcs = 2; v.ret = 1;
                if (op == 6'h03) begin v.rw = 1; v.rd = 2; v.wbs = 2; end
                push_any(v);
            end
            6'h00, 6'h08, 6'h23, 6'h2B: begin
                v = z(2); v.asa = 1;
                if (op == 6'h00) begin v.asb = 0; v.aop = 2; end
                else v.asb = 2;
                push_any(v);
                if (op == 6'h00 || op == 6'h08) begin
                    v = z(5); v.rw = 1; v.ret = 1; v.rd = (op == 6'h00) ? 2'd1 : 2'd0;
                    push_any(v);
                end else if (op == 6'h23) begin
                    v = z(3); v.mr = 1; v.mas = 1;
                    for (int i = 0; i < ms; i++) push(1'b0, 1'($urandom), 6'($urandom), v);
                    push(1'b1, 1'($urandom), 6'($urandom), v);
                    v = z(6); v.rw = 1; v.wbs = 1; v.ret = 1;
                    push_any(v);
                end else begin
                    v = z(4); v.mw = 1; v.mas = 1;
                    for (int i = 0; i < ms; i++) push(1'b0, 1'($urandom), 6'($urandom), v);
                    v.ret = 1;
                    push(1'b1, 1'($urandom), 6'($urandom), v);
                end
            end
            default: begin
                v = z(9); v.hlt = 1;
                for (int i = 0; i < 12; i++) push_any(v);
            end
        endcase
    endtask

    // Called at posedge+1; drives each entry, compares at negedge.
    task automatic run_queue(input int n);
        cyc_t e;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            e = q.pop_front();
            memReady = e.mrdy; aluZero = e.az; opcode = e.op;
            @(negedge clk);
            chk("trace", e.exp);
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_plan_sized(input string name, input logic [5:0] op,
                                  input int fs, input int ms, input logic az,
                                  input int exp_len);
        plan(op, fs, ms, az);
        chk_int(name, q.size(), exp_len);
        run_queue(q.size());
    endtask

    // Reset held for two edges with memReady high, then released at a negedge.
    task automatic do_reset();
        memReady = 1'b1;
        rstN = 1'b0;
        #1 chk("reset_async", RST_V);
        @(posedge clk); #1 chk("reset_hold", RST_V);
        memReady = 1'b0;
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [5:0] legal[7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};

    initial begin
        logic [5:0] op;
        outv_t      v;
        rstN = 1'b0; memReady = 1'b1; aluZero = 1'b0; opcode = 6'h3F;
        #2 chk("reset_init", RST_V);
        @(posedge clk); #1 chk("reset_edge", RST_V);
        memReady = 1'b0;
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;

        run_plan_sized("len_addi", 6'h08, 0, 0, 1'b0, 4);
        run_plan_sized("len_lw_stall2", 6'h23, 0, 2, 1'b0, 7);
        run_plan_sized("len_lw", 6'h23, 0, 0, 1'b0, 5);
        run_plan_sized("len_beq_taken", 6'h04, 0, 0, 1'b1, 3);
        run_plan_sized("len_beq_not", 6'h04, 0, 0, 1'b0, 3);
        run_plan_sized("len_jal", 6'h03, 0, 0, 1'b0, 3);
        run_plan_sized("len_j", 6'h02, 0, 0, 1'b0, 3);
        run_plan_sized("len_sw", 6'h2B, 0, 0, 1'b0, 4);
        run_plan_sized("len_rtype", 6'h00, 0, 0, 1'b0, 4);
        run_plan_sized("len_addi_fstall", 6'h08, 2, 0, 1'b0, 6);

        for (int k = 0; k < 80; k++) begin
            op = legal[$urandom_range(0, 6)];
            plan(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            run_queue(q.size());
        end

        // Abort during a MEM_WR stall: reset mid-cycle must kill memWrite at once.
        plan(6'h2B, 0, 4, 1'b0);
        run_queue(4);
        memReady = 1'b0; opcode = 6'($urandom); aluZero = 1'($urandom);
        v = z(4); v.mw = 1; v.mas = 1;
        @(negedge clk); chk("memwr_stall", v);
        #2 memReady = 1'b1; rstN = 1'b0;
        #1 chk("abort_async", RST_V);
        q.delete();
        @(posedge clk); #1 chk("abort_hold", RST_V);
        memReady = 1'b0;
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        run_plan_sized("len_after_abort", 6'h08, 0, 0, 1'b0, 4);

        run_plan_sized("len_halt", 6'h3F, 0, 0, 1'b0, 14);
        do_reset();
        run_plan_sized("len_after_halt", 6'h00, 1, 0, 1'b0, 5);

        for (int k = 0; k < 4; k++) begin
            do begin
                op = 6'($urandom);
            end while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03});
            plan(op, $urandom_range(0, 2), 0, 1'b0);
            run_queue(q.size());
            do_reset();
            plan(legal[$urandom_range(0, 6)], 0, $urandom_range(0, 2), 1'($urandom));
            run_queue(q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
